// File: rtl/ernic_cmac_tx_pkt_fifo.sv
// Store-and-forward AXIS packet FIFO feeding the CMAC TX path (txusrclk2 domain).
// A packet is released only after its last beat is stored; oversize packets are dropped and counted.
module ernic_cmac_tx_pkt_fifo #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_W-1:0]       s_axis_tdata,
  input  logic [DATA_W/8-1:0]     s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic [DATA_W/8-1:0]     m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic [CNT_W-1:0]        pkt_cnt,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = DATA_W / 8;
  localparam int MW = DATA_W + KW + 1;
  localparam logic [0:0]    ST_WR   = 1'b0;
  localparam logic [0:0]    ST_DROP = 1'b1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [MW-1:0]    mem_q [DEPTH];
  logic [0:0]       wr_st_q, wr_st_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    wr_commit_q, wr_commit_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             s_ready_q, s_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [MW-1:0]    out_q, out_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]    level_q, level_d;

  logic             s_acc_s, wr_en_s, commit_s, oversize_s;
  logic             m_xfer_s, out_load_s, pkt_done_s;
  logic [PW-1:0]    wr_ptr_inc_s, used_s;

  // Write-side state machine: store, commit on tlast, rewind and drop on overflow
  always_comb begin
    s_acc_s      = s_axis_tvalid & s_ready_q;
    wr_ptr_inc_s = wr_ptr_q + PW'(1);
    wr_en_s      = 1'b0;
    commit_s     = 1'b0;
    oversize_s   = 1'b0;
    wr_st_d      = wr_st_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    case (wr_st_q)
      ST_WR: begin
        if (s_acc_s && s_axis_tlast) begin
          wr_en_s     = 1'b1;
          commit_s    = 1'b1;
          wr_ptr_d    = wr_ptr_inc_s;
          wr_commit_d = wr_ptr_inc_s;
        end else if (s_acc_s && ((wr_ptr_inc_s - wr_commit_q) == DEPTH_P)) begin
          oversize_s  = 1'b1;
          wr_ptr_d    = wr_commit_q;
          wr_st_d     = ST_DROP;
        end else if (s_acc_s) begin
          wr_en_s     = 1'b1;
          wr_ptr_d    = wr_ptr_inc_s;
        end else begin
          wr_ptr_d    = wr_ptr_q;
        end
      end
      ST_DROP: begin
        if (s_acc_s && s_axis_tlast) begin
          wr_st_d = ST_WR;
        end else begin
          wr_st_d = ST_DROP;
        end
      end
      default: begin
        wr_st_d = ST_WR;
      end
    endcase
  end

  // Read side: only committed beats (rd_ptr..wr_commit) may enter the output register
  always_comb begin
    m_xfer_s    = out_valid_q & m_axis_tready;
    pkt_done_s  = m_xfer_s & out_q[MW-1];
    out_load_s  = (~out_valid_q | m_axis_tready) & (rd_ptr_q != wr_commit_q);
    rd_ptr_d    = rd_ptr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_load_s) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      out_d       = mem_q[rd_ptr_q[AW-1:0]];
      out_valid_d = 1'b1;
    end else if (m_xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Status counters, occupancy and the registered input-ready flag
  always_comb begin
    case ({commit_s, pkt_done_s})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    if (oversize_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    used_s  = wr_ptr_d - rd_ptr_d;
    level_d = used_s + {{AW{1'b0}}, out_valid_d};
    if (wr_st_d == ST_DROP) begin
      s_ready_d = 1'b1;
    end else begin
      s_ready_d = (used_s != DEPTH_P);
    end
  end

  // Beat storage; rewound or dropped beats are never written
  always_ff @(posedge aclk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

  // Control and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_st_q     <= ST_WR;
      wr_ptr_q    <= {PW{1'b0}};
      wr_commit_q <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      s_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= {MW{1'b0}};
      pkt_cnt_q   <= {CNT_W{1'b0}};
      drop_cnt_q  <= {CNT_W{1'b0}};
      level_q     <= {PW{1'b0}};
    end else begin
      wr_st_q     <= wr_st_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      s_ready_q   <= s_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      level_q     <= level_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_q[MW-1];
  assign m_axis_tkeep  = out_q[MW-2 -: KW];
  assign m_axis_tdata  = out_q[DATA_W-1:0];
  assign m_axis_tuser  = 1'b0;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign fifo_level    = level_q;

endmodule
